// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF controller: FSM state encoding,
// number of oscillator pairs and default counter width.
package ro_puf_pkg;

  localparam int NUM_PAIRS = 8;
  localparam int IDX_W     = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_edge_cnt.sv
// Two-flop synchronizer, rising-edge detector and saturating edge counter for one
// selected oscillator output.
module ro_edge_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise;

  assign rise  = sync2_q & ~prev_q;
  assign cnt_o = cnt_q;

  // Saturate at all-ones so a fast oscillator can never wrap below a slow one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: walks the challenge mask pair by pair, races the
// A and B oscillators of each enabled pair and records which one was faster.
// Optional macro RO_PUF_CTRL_RAW_CNT_EN adds raw_cnt_a/raw_cnt_b count outputs.
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int WIN_CYCLES    = 1024,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_PAIRS-1:0] challenge,
  output logic                 ro_en,
  input  logic [NUM_PAIRS-1:0] ro_a,
  input  logic [NUM_PAIRS-1:0] ro_b,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PAIRS-1:0] response
`ifdef RO_PUF_CTRL_RAW_CNT_EN
  ,
  output logic [CNT_W-1:0]     raw_cnt_a,
  output logic [CNT_W-1:0]     raw_cnt_b
`endif
);

  localparam int TMR_MAX = max_int(SETTLE_CYCLES, WIN_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_PAIRS-1:0] chal_q, chal_d;
  logic [NUM_PAIRS-1:0] resp_q, resp_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [CNT_W-1:0]     cnt_a;
  logic [CNT_W-1:0]     cnt_b;
  logic                 last_idx;
  logic                 cnt_clr;
  logic                 cnt_en;

  assign last_idx = (idx_q == IDX_W'(NUM_PAIRS - 1));
  assign cnt_clr  = (state_q == ST_SETTLE);
  assign cnt_en   = (state_q == ST_MEASURE);

  assign ro_en    = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign response = resp_q;

  // The pair mux sits ahead of the synchronizers; SETTLE absorbs the switch glitch.
  ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .osc_i (ro_a[idx_q]),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_a)
  );

  ro_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .osc_i (ro_b[idx_q]),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_b)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d  = challenge;
          resp_d  = '0;
          idx_d   = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (chal_q[idx_q]) begin
          tmr_d   = '0;
          state_d = ST_SETTLE;
        end else if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (tmr_q == TMR_W'(WIN_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_COMPARE: begin
        // A tie resolves to 0 because only a strictly greater A count sets the bit.
        resp_d[idx_q] = (cnt_a > cnt_b);
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      tmr_q   <= tmr_d;
    end
  end

`ifdef RO_PUF_CTRL_RAW_CNT_EN
  logic [CNT_W-1:0] raw_a_q;
  logic [CNT_W-1:0] raw_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_a_q <= '0;
      raw_b_q <= '0;
    end else if (state_q == ST_COMPARE) begin
      raw_a_q <= cnt_a;
      raw_b_q <= cnt_b;
    end
  end

  assign raw_cnt_a = raw_a_q;
  assign raw_cnt_b = raw_b_q;
`endif

endmodule

// File: doc/ro_puf_ctrl.md
RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles the oscillators run before counting starts.
REQ-002 SHALL have parameter WIN_CYCLES, default 1024: length of the count window in cycles.
REQ-003 SHALL have parameter CNT_W, default 16: width of each edge counter.
REQ-004 SHALL have port clk  in  1: the single clock; rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1: request one challenge evaluation.
REQ-006 SHALL have port challenge  in  8: pair mask; bit i enables oscillator pair i.
REQ-007 SHALL have port ro_en  out  1: enable to the 16-oscillator bank.
REQ-008 SHALL have ports ro_a  in  8 and ro_b  in  8: raw oscillator outputs of bank halves A and B.
REQ-009 SHALL have port busy  out  1: evaluation in progress.
REQ-010 SHALL have port done  out  1: single-cycle completion pulse.
REQ-011 SHALL have port response  out  8: PUF response, bit i from pair i.

Function
REQ-012 SHALL implement the FSM states IDLE, SELECT, SETTLE, MEASURE, COMPARE and DONE.
REQ-013 SHALL, in IDLE with start=1, capture challenge, clear response, set idx=0 and go to SELECT.
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 SHALL, in SELECT, go to SETTLE if challenge_q[idx]=1, otherwise go to DONE if idx=7, otherwise increment idx and stay in SELECT (1 cycle per step).
REQ-016 SHALL hold SETTLE for SETTLE_CYCLES cycles with both counters held at 0, then go to MEASURE.
REQ-017 SHALL hold MEASURE for WIN_CYCLES cycles, counting rising edges of synchronized ro_a[idx] and ro_b[idx].
REQ-018 SHALL, in COMPARE (1 cycle), set response[idx] = (cnt_a > cnt_b), then go to DONE if idx=7, else increment idx and go to SELECT.
REQ-019 SHALL treat a tie (cnt_a = cnt_b) as response bit 0.
REQ-020 SHALL leave response bits of masked pairs at 0.
REQ-021 SHALL drive ro_en=1 only in SETTLE and MEASURE.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-024 SHALL hold response stable from DONE until the next accepted start.
REQ-025 SHALL assert done exactly 8 + N*(SETTLE_CYCLES+WIN_CYCLES+1) cycles after start is sampled, where N = popcount(challenge).
REQ-026 SHALL pass each selected oscillator through a 2-flop synchronizer before edge detection.
REQ-027 SHALL saturate each counter at 2^CNT_W-1 and never let it wrap.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-evaluation, immediately enter IDLE with ro_en, busy, done, response, counters, idx and synchronizers all 0.
REQ-029 SHALL accept a start in the first cycle after rst is released.

Configuration
REQ-030 SHALL, with RO_PUF_CTRL_RAW_CNT_EN defined, add output ports raw_cnt_a and raw_cnt_b (CNT_W each) carrying the counts latched in each COMPARE and held until the next COMPARE or reset.
REQ-031 SHALL, without RO_PUF_CTRL_RAW_CNT_EN, omit those ports and their latches and otherwise behave identically.

Structure
REQ-032 SHALL place the FSM state enum, NUM_PAIRS=8 and the default CNT_W in shared package ro_puf_pkg.
REQ-033 SHALL implement synchronizer, rising-edge detect and saturating counter as sub-module ro_edge_cnt, instantiated twice (A and B).

Verification (SETTLE_CYCLES=4, WIN_CYCLES=32, CNT_W=16 unless stated)
REQ-034 SHALL verify reset: assert rst mid-run -> within the reset cycle ro_en=0, busy=0, done=0, response=0x00.
REQ-035 SHALL verify a full challenge: challenge=0xFF, ro_a period 4 clk, ro_b period 6 clk -> response=0xFF, done 304 cycles after start.
REQ-036 SHALL verify masking: challenge=0x05, pair 0 with A faster, pair 2 with B faster -> response=0x01, done after 82 cycles, ro_en low during every SELECT.
REQ-037 SHALL verify ties: identical A/B waveforms, challenge=0x80 -> response=0x00, done after 45 cycles.
REQ-038 SHALL verify start handling: start pulsed during MEASURE -> ignored, a single done; challenge=0x00 -> done after 8 cycles, response=0x00.
REQ-039 SHALL verify saturation: CNT_W=4, WIN_CYCLES=64, A period 2 and B period 4 -> both counters reach 15, response bit 0 (tie).
